cpu_multicycle_ctrl: RTL

CPU_MULTICYCLE_CTRL -- requirements
Module: cpu_multicycle_ctrl

---
 rtl/cpu_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_multicycle_ctrl.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/writeback states,
// decodes opcodes, supervises memory handshakes with a timeout and raises exceptions.
module cpu_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,   // 1..255 wait cycles before a memory timeout
  parameter bit          SUPPORT_IMM = 1'b1  // enables addi and bne decode
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] instruction_opcode,
  input  logic       hazard_detected,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       ir_write,
  output logic       memread_ctrl,
  output logic       memwrite_ctrl,
  output logic       memtoreg_ctrl,
  output logic       regdst_ctrl,
  output logic       regwrite_ctrl,
  output logic       alusrc_a_ctrl,
  output logic [1:0] alusrc_b_ctrl,
  output logic [1:0] aluop_ctrl,
  output logic [1:0] pc_source,
  output logic       branch_ne,
  output logic       decode_exception_detected,
  output logic [1:0] exception_cause,
  output logic [3:0] ctrl_state
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StAddiEx = 4'd11,
    StAddiWb = 4'd12,
    StExcept = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       in_wait;
  logic       timeout;

  assign in_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // The cycle whose missed handshake would bring the counter to MEM_TIMEOUT; a late
  // mem_ready in that same cycle still completes the access normally.
  assign timeout = in_wait && !mem_ready && (wait_cnt_q == TimeoutLast);

  // Next-state, exception cause and wait-counter update.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StExcept;
          cause_d = CauseTimeout;
        end
      end
      StDecode: begin
        if (!hazard_detected) begin
          case (instruction_opcode)
            OpRtype:    state_d = StExec;
            OpLw, OpSw: state_d = StMemAdr;
            OpBeq:      state_d = StBranch;
            OpJ:        state_d = StJump;
            OpBne:      state_d = SUPPORT_IMM ? StBranch : StExcept;
            OpAddi:     state_d = SUPPORT_IMM ? StAddiEx : StExcept;
            default:    state_d = StExcept;
          endcase
          if (state_d == StExcept) cause_d = CauseIllegal;
        end
      end
      StMemAdr: begin
        if (instruction_opcode == OpLw) begin
          state_d = StMemRd;
        end else if (instruction_opcode == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StExcept;
          cause_d = CauseIllegal;
        end
      end
      StMemRd: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d = StExcept;
          cause_d = CauseTimeout;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          state_d = StExcept;
          cause_d = CauseTimeout;
        end
      end
      StMemWb:  state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StExcept: state_d = StFetch;
      default: begin
        // Unused encodings 14/15 recover through the exception path.
        state_d = StExcept;
        cause_d = CauseIllegal;
      end
    endcase

    // Counter restarts on every state change, so each wait state is entered at zero.
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (in_wait && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State, counter and cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    pc_write                  = 1'b0;
    pc_write_cond             = 1'b0;
    iord                      = 1'b0;
    ir_write                  = 1'b0;
    memread_ctrl              = 1'b0;
    memwrite_ctrl             = 1'b0;
    memtoreg_ctrl             = 1'b0;
    regdst_ctrl               = 1'b0;
    regwrite_ctrl             = 1'b0;
    alusrc_a_ctrl             = 1'b0;
    alusrc_b_ctrl             = 2'b00;
    aluop_ctrl                = 2'b00;
    pc_source                 = 2'b00;
    branch_ne                 = 1'b0;
    decode_exception_detected = 1'b0;
    case (state_q)
      StFetch: begin
        memread_ctrl  = 1'b1;
        alusrc_b_ctrl = 2'b01;
        ir_write      = mem_ready;
        pc_write      = mem_ready;
      end
      StDecode: alusrc_b_ctrl = 2'b11;
      StMemAdr: begin
        alusrc_a_ctrl = 1'b1;
        alusrc_b_ctrl = 2'b10;
      end
      StMemRd: begin
        memread_ctrl = 1'b1;
        iord         = 1'b1;
      end
      StMemWb: begin
        regwrite_ctrl = 1'b1;
        memtoreg_ctrl = 1'b1;
      end
      StMemWr: begin
        memwrite_ctrl = !timeout;
        iord          = 1'b1;
      end
      StExec: begin
        alusrc_a_ctrl = 1'b1;
        aluop_ctrl    = 2'b10;
      end
      StAluWb: begin
        regdst_ctrl   = 1'b1;
        regwrite_ctrl = 1'b1;
      end
      StBranch: begin
        alusrc_a_ctrl = 1'b1;
        aluop_ctrl    = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (instruction_opcode == OpBne);
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StAddiEx: begin
        alusrc_a_ctrl = 1'b1;
        alusrc_b_ctrl = 2'b10;
      end
      StAddiWb: regwrite_ctrl = 1'b1;
      StExcept: begin
        decode_exception_detected = 1'b1;
        pc_write                  = 1'b1;
        pc_source                 = 2'b11;
      end
      default: ;
    endcase
  end

  assign ctrl_state      = state_q;
  assign exception_cause = cause_q;

endmodule
